// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM below the MMIO boundary, timer/compare/IRQ and GPIO
// registers above it. Reads are registered (1-cycle latency, read-before-write).
module dmem_responder #(
  parameter int unsigned DMEM_WIDTH = 16,
  parameter int unsigned GPIO_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DMEM_WIDTH-1:0] data_mem_addr,
  input  logic [3:0]            data_mem_wmask,
  input  logic [31:0]           data_mem_write,
  input  logic                  data_mem_w_en,
  output logic [31:0]           data_mem_read,
  output logic [GPIO_W-1:0]     gpio_out,
  output logic                  timer_irq
);

  localparam int unsigned IdxW     = DMEM_WIDTH - 3;
  localparam int unsigned RamWords = 1 << IdxW;

  localparam logic [2:0] OffTimer  = 3'd0;
  localparam logic [2:0] OffCmp    = 3'd1;
  localparam logic [2:0] OffCtrl   = 3'd2;
  localparam logic [2:0] OffStatus = 3'd3;
  localparam logic [2:0] OffGpio   = 3'd4;

  logic [31:0] mem [RamWords];

  logic            is_mmio;
  logic [IdxW-1:0] ram_idx;
  logic [2:0]      mmio_off;
  logic            wr_ram;
  logic            wr_mmio;

  logic [31:0]       timer_q, timer_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              timer_en_q, timer_en_d;
  logic              irq_en_q, irq_en_d;
  logic              match_q, match_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mmio_rdata;

  // Byte-address bits below word granularity carry no information.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^data_mem_addr[1:0];

  assign is_mmio  = data_mem_addr[DMEM_WIDTH-1];
  assign ram_idx  = data_mem_addr[DMEM_WIDTH-2:2];
  assign mmio_off = data_mem_addr[4:2];
  assign wr_ram   = data_mem_w_en & ~is_mmio;
  assign wr_mmio  = data_mem_w_en & is_mmio;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int unsigned b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_mem_wmask[b]) mem[ram_idx][8*b +: 8] <= data_mem_write[8*b +: 8];
      end
    end
  end

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_off)
      OffTimer:  mmio_rdata = timer_q;
      OffCmp:    mmio_rdata = cmp_q;
      OffCtrl:   mmio_rdata = {30'h0, irq_en_q, timer_en_q};
      OffStatus: mmio_rdata = {31'h0, match_q};
      OffGpio:   mmio_rdata = 32'(gpio_q);
      default:   mmio_rdata = 32'h0;
    endcase
    rdata_d = is_mmio ? mmio_rdata : mem[ram_idx];
  end

  always_comb begin
    timer_d    = timer_en_q ? timer_q + 32'd1 : timer_q;
    cmp_d      = cmp_q;
    timer_en_d = timer_en_q;
    irq_en_d   = irq_en_q;
    gpio_d     = gpio_q;
    match_d    = match_q | (timer_en_q & (timer_q == cmp_q));

    if (wr_mmio) begin
      case (mmio_off)
        OffTimer: timer_d = merge_lanes(timer_q, data_mem_write, data_mem_wmask);
        OffCmp:   cmp_d   = merge_lanes(cmp_q, data_mem_write, data_mem_wmask);
        OffCtrl: begin
          if (data_mem_wmask[0]) begin
            timer_en_d = data_mem_write[0];
            irq_en_d   = data_mem_write[1];
          end
        end
        OffStatus: begin
          // W1C, but a match landing on the same edge wins.
          if (data_mem_wmask[0] && data_mem_write[0]) begin
            match_d = timer_en_q & (timer_q == cmp_q);
          end
        end
        OffGpio: begin
          for (int unsigned i = 0; i < GPIO_W; i++) begin
            gpio_d[i] = data_mem_wmask[i[4:3]] ? data_mem_write[i] : gpio_q[i];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q    <= 32'h0;
      cmp_q      <= 32'hFFFF_FFFF;
      timer_en_q <= 1'b0;
      irq_en_q   <= 1'b0;
      match_q    <= 1'b0;
      gpio_q     <= '0;
      rdata_q    <= 32'h0;
    end else begin
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      timer_en_q <= timer_en_d;
      irq_en_q   <= irq_en_d;
      match_q    <= match_d;
      gpio_q     <= gpio_d;
      rdata_q    <= rdata_d;
    end
  end

  assign data_mem_read = rdata_q;
  assign gpio_out      = gpio_q;
  assign timer_irq     = match_q & irq_en_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for RAM/MMIO decode plus
// hand-written timer, wrap/priority and mid-cycle reset sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_mem_addr;
  logic [3:0]  data_mem_wmask;
  logic [31:0] data_mem_write;
  logic        data_mem_w_en;
  logic [31:0] data_mem_read;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int n_checks = 0;
  int n_fails  = 0;

  dmem_responder #(
    .DMEM_WIDTH(16),
    .GPIO_W    (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_mem_addr (data_mem_addr),
    .data_mem_wmask(data_mem_wmask),
    .data_mem_write(data_mem_write),
    .data_mem_w_en (data_mem_w_en),
    .data_mem_read (data_mem_read),
    .gpio_out      (gpio_out),
    .timer_irq     (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_gpio;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                              input logic w, input logic c, input logic [31:0] er,
                              input logic [7:0] eg);
    vec_t v;
    v.addr = a; v.wdata = d; v.wmask = m; v.wen = w;
    v.chk_rd = c; v.exp_rd = er; v.exp_gpio = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one cycle of inputs, then return 1 time unit after the capturing edge.
  task automatic cyc(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic w);
    data_mem_addr  = a;
    data_mem_write = d;
    data_mem_wmask = m;
    data_mem_w_en  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a);
    cyc(a, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    data_mem_addr  = 16'h0;
    data_mem_write = 32'h0;
    data_mem_wmask = 4'h0;
    data_mem_w_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset read", data_mem_read, 32'h0);
    chk("reset gpio", 32'(gpio_out), 32'h0);
    chk("reset irq", 32'(timer_irq), 32'h0);
    reset = 1'b0;

    vecs.push_back(mk(16'h0010, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 32'h0, 8'h00));
    vecs.push_back(mk(16'h0010, 32'h0000_AA00, 4'h2, 1'b1, 1'b1, 32'h1122_3344, 8'h00));
    vecs.push_back(mk(16'h0010, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1122_AA44, 8'h00));
    vecs.push_back(mk(16'h0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 32'h1122_AA44, 8'h00));
    vecs.push_back(mk(16'h0010, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'h00));
    vecs.push_back(mk(16'h0020, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'h0, 8'h00));
    vecs.push_back(mk(16'h0023, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 8'h00));
    vecs.push_back(mk(16'h8004, 32'h0, 4'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 8'h00));
    vecs.push_back(mk(16'h8008, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 8'h00));
    vecs.push_back(mk(16'h8014, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0, 8'h00));
    vecs.push_back(mk(16'h8018, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0, 8'h00));
    vecs.push_back(mk(16'h801C, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0, 8'h00));
    vecs.push_back(mk(16'h8014, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 8'h00));
    vecs.push_back(mk(16'h8018, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 8'h00));
    vecs.push_back(mk(16'h8010, 32'h0000_01FF, 4'hF, 1'b1, 1'b1, 32'h0, 8'hFF));
    vecs.push_back(mk(16'h8010, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_00FF, 8'hFF));
    vecs.push_back(mk(16'h8030, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_00FF, 8'hFF));
    vecs.push_back(mk(16'h8010, 32'h0000_0012, 4'h0, 1'b1, 1'b1, 32'h0000_00FF, 8'hFF));
    vecs.push_back(mk(16'h8010, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_00FF, 8'hFF));
    vecs.push_back(mk(16'h8004, 32'h00AB_0000, 4'h4, 1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF));
    vecs.push_back(mk(16'h8004, 32'h0, 4'h0, 1'b0, 1'b1, 32'hFFAB_FFFF, 8'hFF));
    vecs.push_back(mk(16'h8008, 32'hFFFF_FFFE, 4'hF, 1'b1, 1'b1, 32'h0, 8'hFF));
    vecs.push_back(mk(16'h8008, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0002, 8'hFF));
    vecs.push_back(mk(16'h8000, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 8'hFF));
    vecs.push_back(mk(16'h0010, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'hFF));

    foreach (vecs[i]) begin
      cyc(vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].wen);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d read", i), data_mem_read, vecs[i].exp_rd);
      chk($sformatf("vec%0d gpio", i), 32'(gpio_out), 32'(vecs[i].exp_gpio));
      chk($sformatf("vec%0d irq", i), 32'(timer_irq), 32'h0);
    end

    // Timer match and IRQ: CMP=5, TIMER=0, then enable timer and irq.
    cyc(16'h8004, 32'd5, 4'hF, 1'b1);
    cyc(16'h8000, 32'd0, 4'hF, 1'b1);
    cyc(16'h8008, 32'd3, 4'h1, 1'b1);
    for (int k = 0; k < 5; k++) rd(16'h800C);
    chk("irq before match", 32'(timer_irq), 32'h0);
    chk("status before match", data_mem_read, 32'h0);
    rd(16'h800C);
    chk("irq after match", 32'(timer_irq), 32'h1);
    rd(16'h800C);
    chk("status match read", data_mem_read, 32'h1);
    cyc(16'h800C, 32'h1, 4'h1, 1'b1);
    chk("w1c pre read", data_mem_read, 32'h1);
    chk("irq after w1c", 32'(timer_irq), 32'h0);
    rd(16'h800C);
    chk("status after w1c", data_mem_read, 32'h0);

    // Set and clear on the same edge: set wins.
    cyc(16'h8000, 32'd4, 4'hF, 1'b1);
    rd(16'h800C);
    cyc(16'h800C, 32'h1, 4'h1, 1'b1);
    chk("set+clear irq", 32'(timer_irq), 32'h1);
    cyc(16'h800C, 32'h1, 4'h1, 1'b1);
    chk("set+clear status", data_mem_read, 32'h1);
    chk("second w1c irq", 32'(timer_irq), 32'h0);

    // Wrap and write priority while counting.
    cyc(16'h8000, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(16'h8000);
    chk("timer max", data_mem_read, 32'hFFFF_FFFF);
    rd(16'h8000);
    chk("timer wrap", data_mem_read, 32'h0);
    cyc(16'h8000, 32'd7, 4'hF, 1'b1);
    chk("timer pre write", data_mem_read, 32'h1);
    rd(16'h8000);
    chk("timer loaded", data_mem_read, 32'd7);
    rd(16'h8000);
    chk("timer incr", data_mem_read, 32'd8);

    // Reset between edges with timer running, IRQ raised and GPIO=0xA5.
    cyc(16'h8010, 32'h0000_00A5, 4'h1, 1'b1);
    chk("gpio a5", 32'(gpio_out), 32'h0000_00A5);
    cyc(16'h8000, 32'd5, 4'hF, 1'b1);
    rd(16'h8010);
    chk("pre-reset read", data_mem_read, 32'h0000_00A5);
    chk("pre-reset irq", 32'(timer_irq), 32'h1);
    #3 reset = 1'b1;
    #1;
    chk("async reset read", data_mem_read, 32'h0);
    chk("async reset gpio", 32'(gpio_out), 32'h0);
    chk("async reset irq", 32'(timer_irq), 32'h0);
    reset = 1'b0;
    rd(16'h8004);
    chk("cmp after reset", data_mem_read, 32'hFFFF_FFFF);
    rd(16'h8008);
    chk("ctrl after reset", data_mem_read, 32'h0);
    rd(16'h800C);
    chk("status after reset", data_mem_read, 32'h0);
    rd(16'h8000);
    chk("timer after reset", data_mem_read, 32'h0);
    rd(16'h0010);
    chk("ram kept 0010", data_mem_read, 32'hDEAD_BEEF);
    rd(16'h0020);
    chk("ram kept 0020", data_mem_read, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DMEM_WIDTH, default 16, byte-address width of the data port (word-aligned addresses).
REQ-002 SHALL have parameter GPIO_W, default 8, GPIO output width.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port data_mem_addr  input  DMEM_WIDTH  word-aligned byte address from CPU.
REQ-007 SHALL have port data_mem_wmask  input  4  byte-lane write mask.
REQ-008 SHALL have port data_mem_write  input  32  write data, lane-aligned.
REQ-009 SHALL have port data_mem_w_en  input  1  write strobe.
REQ-010 SHALL have port data_mem_read  output  32  registered read data.
REQ-011 SHALL have port gpio_out  output  GPIO_W  GPIO register value.
REQ-012 SHALL have port timer_irq  output  1  timer interrupt level.

Function
REQ-013 SHALL decode data_mem_addr[DMEM_WIDTH-1]: 0 selects RAM, 1 selects MMIO.
REQ-014 SHALL hold RAM of 2^(DMEM_WIDTH-3) 32-bit words, indexed by data_mem_addr[DMEM_WIDTH-2:2]; data_mem_addr[1:0] ignored.
REQ-015 SHALL write a RAM word on the rising clk edge when data_mem_w_en=1, updating only lanes whose data_mem_wmask bit is 1.
REQ-016 SHALL register data_mem_read every cycle from the address presented that cycle (1-cycle latency, no handshake, no enable).
REQ-017 SHALL return pre-write contents on data_mem_read when a read and write target the same word in the same cycle (read-before-write).
REQ-018 SHALL decode MMIO registers by data_mem_addr[4:2]: 0 TIMER, 1 CMP, 2 CTRL, 3 STATUS, 4 GPIO; offsets 5-7 and upper MMIO bits ignored (aliasing).
REQ-019 SHALL read offsets 5-7 as 0 and ignore writes to them.
REQ-020 SHALL apply data_mem_wmask per byte to MMIO writes, as for RAM.
REQ-021 CTRL: bit0 timer_en, bit1 irq_en; bits 31:2 read 0.
REQ-022 TIMER SHALL increment by 1 per cycle when timer_en=1, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-023 A TIMER write SHALL take priority over the increment in that cycle (written value loaded, no increment).
REQ-024 STATUS bit0 (match) SHALL be set on the next edge when timer_en=1 and TIMER==CMP (compare uses pre-update values), and is sticky.
REQ-025 STATUS bit0 SHALL clear on a write with wmask[0]=1 and data bit0=1 (W1C); a simultaneous set and clear SHALL leave it set.
REQ-026 STATUS bits 31:1 SHALL read 0.
REQ-027 timer_irq SHALL equal STATUS.match AND irq_en, combinational from registers.
REQ-028 GPIO SHALL store the low GPIO_W bits and drive gpio_out directly; upper bits read 0.
REQ-029 MMIO reads SHALL have the same 1-cycle registered latency and read-before-write semantics as RAM.

Reset
REQ-030 On reset assertion, asynchronously: data_mem_read=0, TIMER=0, CMP=0xFFFFFFFF, CTRL=0, STATUS=0, GPIO=0, gpio_out=0, timer_irq=0.
REQ-031 RAM contents SHALL NOT be reset.
REQ-032 A write coincident with reset SHALL be dropped for MMIO; the RAM write is undefined.
REQ-033 After reset deasserts, the first edge SHALL perform normal operation.

Verification
REQ-034 RAM byte write: write 0x11223344 mask 1111 to 0x0010, then 0x0000AA00 mask 0010 -> read 0x0010 returns 0x1122AA44 one cycle after address.
REQ-035 Read-before-write: read and write 0xDEADBEEF to the same word in one cycle -> that cycle's read returns the old value; the next read returns 0xDEADBEEF.
REQ-036 Timer/IRQ: CMP=5, CTRL=3, TIMER=0 -> STATUS.match set and timer_irq=1 one cycle after TIMER==5; W1C STATUS clears both.
REQ-037 Wrap and priority: TIMER=0xFFFFFFFF with timer_en=1 -> next value 0; a TIMER write of 7 during counting -> reads 7, then 8.
REQ-038 Reset mid-operation: with timer running and GPIO=0xA5, assert reset between edges -> all outputs zero immediately and CMP reads 0xFFFFFFFF; RAM data preserved.
REQ-039 MMIO decode: write offsets 5-7 then read -> 0; GPIO write 0x1FF -> gpio_out=0xFF (GPIO_W=8), reads 0x000000FF.
